// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
// Shared definitions for the AXI-Stream arbiters of the accelerator.
//   - Global width constants (ROWS, WORD_WIDTH_ACC, TUSER_WIDTH_CONV_OUT,
//     N_OUT_SRC). Each has a fallback default so this slice builds on its own
//     when the global params.v is not part of the compile.
//   - arb_state_e : arbiter state (IDLE / GRANT).
//   - rr_pick()   : rotate-priority search, reusable by input-side arbiters.
// ---------------------------------------------------------------------------
`ifndef ROWS
`define ROWS 4
`endif
`ifndef WORD_WIDTH_ACC
`define WORD_WIDTH_ACC 32
`endif
`ifndef TUSER_WIDTH_CONV_OUT
`define TUSER_WIDTH_CONV_OUT 8
`endif
`ifndef N_OUT_SRC
`define N_OUT_SRC 2
`endif

package axis_arb_pkg;

   // Largest source count rr_pick can search. Callers zero-extend their
   // request vector to this width.
   localparam int RR_MAX_SRC = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Returns the first asserted request when scanning ptr, ptr+1, ... and
   // wrapping modulo nSrc. If nothing is requested it returns ptr. Callers
   // only use the result when at least one request is present.
   function automatic int rr_pick(input logic [RR_MAX_SRC-1:0] valid,
                                  input int ptr,
                                  input int nSrc);
      int pick;
      int idx;
      logic found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < RR_MAX_SRC; k++) begin
         idx = (ptr + k) % nSrc;
         if ((k < nSrc) && !found && valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axis_out_arb_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
// Single-stage output register of the arbiter. It loads a payload when the
// arbiter accepts a beat. It drops valid when downstream takes the beat and
// nothing new arrives. Otherwise it holds its contents.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   i_load        : a beat is accepted this cycle (load the payload, set valid)
//   i_ready       : downstream ready
//   i_data        : payload to load
//   o_valid       : register holds a beat
//   o_data        : registered payload
// ---------------------------------------------------------------------------
module axis_reg_slice #(
   parameter int WIDTH = 8
)(
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             i_load,
   input  logic             i_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // A load has priority over a drain. When a beat leaves and the next
   // arrives in the same cycle, valid stays high with the new contents.
   // Data is held unless a load occurs, so it stays stable under stall.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/axis_out_arb.sv
// ---------------------------------------------------------------------------
// axis_out_arb
// Packet-level round-robin arbiter. It merges N_SRC axis_out_shift streams
// into one registered ROWS-wide output stream. The grant is locked from the
// first beat of a packet through the beat carrying s_last, so packets never
// interleave.
// Ports:
//   aclk, aresetn   : clock, asynchronous active-low reset
//   s_valid/s_last  : per-source valid / end of packet        [N_SRC]
//   s_ready         : per-source ready                        [N_SRC]
//   s_data          : per-source beat, source i at slice i    [N_SRC*ROWS*WORD_WIDTH]
//   s_user          : per-source user sideband                [N_SRC*TUSER_WIDTH]
//   m_ready         : downstream ready
//   m_valid/m_last  : output valid / end of packet
//   m_data/m_user   : output beat / user sideband
//   m_src           : index of the source that produced the current beat
// ---------------------------------------------------------------------------
module axis_out_arb
   import axis_arb_pkg::*;
#(
   parameter int N_SRC       = `N_OUT_SRC,
   parameter int ROWS        = `ROWS,
   parameter int WORD_WIDTH  = `WORD_WIDTH_ACC,
   parameter int TUSER_WIDTH = `TUSER_WIDTH_CONV_OUT,
   parameter int BITS_SRC    = $clog2(N_SRC)
)(
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [N_SRC-1:0]                  s_valid,
   input  logic [N_SRC-1:0]                  s_last,
   output logic [N_SRC-1:0]                  s_ready,
   input  logic [N_SRC*ROWS*WORD_WIDTH-1:0]  s_data,
   input  logic [N_SRC*TUSER_WIDTH-1:0]      s_user,
   input  logic                              m_ready,
   output logic                              m_valid,
   output logic                              m_last,
   output logic [ROWS*WORD_WIDTH-1:0]        m_data,
   output logic [TUSER_WIDTH-1:0]            m_user,
   output logic [BITS_SRC-1:0]               m_src
);

   localparam int BEAT_W = ROWS * WORD_WIDTH;
   localparam int PAY_W  = 1 + BITS_SRC + TUSER_WIDTH + BEAT_W;

   arb_state_e          r_state;
   logic [BITS_SRC-1:0] r_grant;
   logic [BITS_SRC-1:0] r_ptr;
   logic [BITS_SRC-1:0] w_nextPtr;

   logic                   w_selValid;
   logic                   w_selLast;
   logic [BEAT_W-1:0]      w_selData;
   logic [TUSER_WIDTH-1:0] w_selUser;

   logic             w_slotFree;
   logic             w_accept;
   logic             w_acceptLast;
   logic             w_mValid;
   logic [PAY_W-1:0] w_payIn;
   logic [PAY_W-1:0] w_payOut;

   // Select the granted source's signals.
   assign w_selValid = s_valid[r_grant];
   assign w_selLast  = s_last[r_grant];
   assign w_selData  = s_data[int'(r_grant)*BEAT_W +: BEAT_W];
   assign w_selUser  = s_user[int'(r_grant)*TUSER_WIDTH +: TUSER_WIDTH];

   // The output register can take a new beat when it is empty or is being
   // emptied this cycle. This gives a combinational path from m_ready to
   // s_ready and keeps one beat per cycle inside a packet.
   assign w_slotFree   = !w_mValid || m_ready;
   assign w_accept     = (r_state == GRANT) && w_selValid && w_slotFree;
   assign w_acceptLast = w_accept && w_selLast;

   // The pointer moves to the source after the one just served, wrapping
   // from N_SRC-1 to 0.
   assign w_nextPtr = (r_grant == BITS_SRC'(N_SRC - 1)) ? '0 : r_grant + 1'b1;

   // Only the granted source ever sees ready. s_ready stays 0 in IDLE, so
   // the arbitration cycle never accepts a beat.
   always_comb begin
      s_ready = '0;
      if (r_state == GRANT) begin
         s_ready[r_grant] = w_slotFree;
      end
   end

   // Grant FSM. IDLE picks a source in rotating order. GRANT holds that
   // source through bubbles until its last beat is accepted. A new grant may
   // be issued while the previous last beat still waits in the output
   // register. The first beat of the new grant then waits on w_slotFree.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|s_valid) begin
                  r_state <= GRANT;
                  r_grant <= BITS_SRC'(rr_pick(RR_MAX_SRC'(s_valid), int'(r_ptr), N_SRC));
               end
            end
            GRANT: begin
               if (w_acceptLast) begin
                  r_state <= IDLE;
                  r_ptr   <= w_nextPtr;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // The source index travels with the beat, so m_src always names the
   // producer of the beat on the output, even after the grant has moved on.
   assign w_payIn = {w_selLast, r_grant, w_selUser, w_selData};

   axis_reg_slice #(
      .WIDTH (PAY_W)
   ) u_outReg (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_load  (w_accept),
      .i_ready (m_ready),
      .i_data  (w_payIn),
      .o_valid (w_mValid),
      .o_data  (w_payOut)
   );

   assign m_valid = w_mValid;
   assign {m_last, m_src, m_user, m_data} = w_payOut;

endmodule

// File: tb/tb_axis_out_arb.sv
// ---------------------------------------------------------------------------
// tb_axis_out_arb
// Self-checking bench for axis_out_arb with three sources. Directed packet
// scenarios and a randomized phase are checked every cycle against a
// packet-level reference model. Literal expectations pin key sequences.
// ---------------------------------------------------------------------------
module tb_axis_out_arb;

   localparam int N    = 3;
   localparam int ROWS = 2;
   localparam int WW   = 8;
   localparam int UW   = 4;
   localparam int DW   = ROWS * WW;
   localparam int BS   = 2;

   typedef struct packed {
      logic          last;
      logic [UW-1:0] user;
      logic [DW-1:0] data;
   } beat_t;

   logic              aclk    = 1'b0;
   logic              aresetn = 1'b1;
   logic [N-1:0]      s_valid = '0;
   logic [N-1:0]      s_last  = '0;
   logic [N-1:0]      s_ready;
   logic [N*DW-1:0]   s_data  = '0;
   logic [N*UW-1:0]   s_user  = '0;
   logic              m_ready = 1'b0;
   logic              m_valid;
   logic              m_last;
   logic [DW-1:0]     m_data;
   logic [UW-1:0]     m_user;
   logic [BS-1:0]     m_src;

   axis_out_arb #(
      .N_SRC       (N),
      .ROWS        (ROWS),
      .WORD_WIDTH  (WW),
      .TUSER_WIDTH (UW),
      .BITS_SRC    (BS)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_user  (s_user),
      .m_ready (m_ready),
      .m_valid (m_valid),
      .m_last  (m_last),
      .m_data  (m_data),
      .m_user  (m_user),
      .m_src   (m_src)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   // Stimulus state: pending beats per source, bubble flags, downstream ready
   beat_t srcQ [N][$];
   bit    stall [N];
   bit    mReadyDrv;

   // Reference model: owner = -1 when no source holds the output
   int            mOwner;
   int            mPtr;
   bit            mValid;
   bit            mLast;
   logic [DW-1:0] mData;
   logic [UW-1:0] mUser;
   int            mSrc;

   // Beats observed leaving the DUT (m_valid && m_ready before an edge)
   int            srcLog[$];
   logic [DW-1:0] dataLog[$];
   bit            lastLog[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mOwner = -1;
      mPtr   = 0;
      mValid = 1'b0;
      mLast  = 1'b0;
      mData  = '0;
      mUser  = '0;
      mSrc   = 0;
   endtask

   task automatic pushPacket(input int src, input int len, input logic [DW-1:0] base);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = base + DW'(k);
         b.user = UW'($urandom);
         b.last = (k == len - 1);
         srcQ[src].push_back(b);
      end
   endtask

   // Present each source's head beat, unless the source is in a bubble.
   // Idle sources put junk on their data lanes.
   task automatic applyStimulus();
      for (int i = 0; i < N; i++) begin
         if ((srcQ[i].size() > 0) && !stall[i]) begin
            s_valid[i]             = 1'b1;
            s_last[i]              = srcQ[i][0].last;
            s_data[i*DW +: DW]     = srcQ[i][0].data;
            s_user[i*UW +: UW]     = srcQ[i][0].user;
         end else begin
            s_valid[i]             = 1'b0;
            s_last[i]              = 1'($urandom);
            s_data[i*DW +: DW]     = DW'($urandom);
            s_user[i*UW +: UW]     = UW'($urandom);
         end
      end
      m_ready = mReadyDrv;
   endtask

   task automatic checkOutput();
      logic [N-1:0] expReady;
      expReady = '0;
      if (mOwner >= 0) expReady[mOwner] = !mValid || mReadyDrv;
      check("m_valid", 32'(m_valid), 32'(mValid));
      check("m_last",  32'(m_last),  32'(mLast));
      check("m_data",  32'(m_data),  32'(mData));
      check("m_user",  32'(m_user),  32'(mUser));
      check("m_src",   32'(m_src),   32'(mSrc));
      check("s_ready", 32'(s_ready), 32'(expReady));
   endtask

   // Advance the model by one clock edge using the inputs being driven
   task automatic modelAdvance();
      bit    ready;
      bit    accept;
      beat_t b;
      b = '0;
      if (m_valid && m_ready) begin
         srcLog.push_back(int'(m_src));
         dataLog.push_back(m_data);
         lastLog.push_back(m_last);
      end
      ready  = (mOwner >= 0) && (!mValid || mReadyDrv);
      accept = ready && s_valid[mOwner];
      if (accept) begin
         b      = srcQ[mOwner].pop_front();
         mValid = 1'b1;
         mData  = b.data;
         mUser  = b.user;
         mLast  = b.last;
         mSrc   = mOwner;
      end else if (mReadyDrv) begin
         mValid = 1'b0;
      end
      if (mOwner < 0) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (s_valid[(mPtr + k) % N]) mOwner = (mPtr + k) % N;
         end
      end else if (accept && b.last) begin
         mPtr   = (mOwner + 1) % N;
         mOwner = -1;
      end
   endtask

   task automatic runCycle();
      applyStimulus();
      #1;
      checkOutput();
      modelAdvance();
      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic doReset();
      @(negedge aclk);
      aresetn = 1'b0;
      for (int i = 0; i < N; i++) begin
         srcQ[i].delete();
         stall[i] = 1'b0;
      end
      mReadyDrv = 1'b1;
      applyStimulus();
      modelReset();
      #1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_last",  32'(m_last),  32'd0);
      check("rst_m_data",  32'(m_data),  32'd0);
      check("rst_m_src",   32'(m_src),   32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      srcLog.delete();
      dataLog.delete();
      lastLog.delete();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic drain(input string name, input int budget);
      int  n;
      bit  busy;
      n = 0;
      busy = 1'b1;
      while (busy && (n < budget)) begin
         runCycle();
         n++;
         busy = mValid || (mOwner >= 0);
         for (int i = 0; i < N; i++) if (srcQ[i].size() > 0) busy = 1'b1;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: drain timeout after %0d cycles", name, budget);
      end
   endtask

   task automatic checkSrcSeq(input string name, input int exp[]);
      check({name, "_count"}, 32'(srcLog.size()), 32'(exp.size()));
      for (int k = 0; k < exp.size(); k++) begin
         if (k < srcLog.size()) check(name, 32'(srcLog[k]), 32'(exp[k]));
      end
   endtask

   initial begin
      int pat[10];
      int expSeq[];

      // ---- single source, 4 beats, data 1..4 ----
      doReset();
      pushPacket(0, 4, 16'd1);
      runCycle();
      check("t1_arb_cycle_valid", 32'(m_valid), 32'd0);
      runCycle();
      check("t1_first_valid", 32'(m_valid), 32'd1);
      check("t1_first_data",  32'(m_data),  32'd1);
      check("t1_first_src",   32'(m_src),   32'd0);
      check("t1_first_last",  32'(m_last),  32'd0);
      runCycle();
      check("t1_beat2", 32'(m_data), 32'd2);
      runCycle();
      check("t1_beat3", 32'(m_data), 32'd3);
      runCycle();
      check("t1_beat4",      32'(m_data),  32'd4);
      check("t1_beat4_last", 32'(m_last),  32'd1);
      check("t1_beat4_val",  32'(m_valid), 32'd1);
      runCycle();
      check("t1_done_valid", 32'(m_valid), 32'd0);
      drain("t1", 50);

      // ---- contention: two 3-beat packets on src0 and src1, two rounds ----
      doReset();
      pushPacket(0, 3, 16'h0100);
      pushPacket(0, 3, 16'h0200);
      pushPacket(1, 3, 16'h1100);
      pushPacket(1, 3, 16'h1200);
      repeat (5) runCycle();
      check("t2_bubble", 32'(m_valid), 32'd0);
      drain("t2", 200);
      expSeq = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
      checkSrcSeq("t2_src_seq", expSeq);
      if (dataLog.size() == 12) begin
         check("t2_data_first_r2", 32'(dataLog[6]), 32'h0200);
         check("t2_data_last",     32'(dataLog[11]), 32'h1202);
      end

      // ---- back-pressure during a 4-beat packet ----
      doReset();
      pushPacket(0, 4, 16'd1);
      pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
      for (int c = 0; c < 10; c++) begin
         mReadyDrv = pat[c][0];
         if (pat[c] == 0) begin
            applyStimulus();
            #1;
            check("t3_stall_sready", 32'(s_ready[0]), 32'd0);
            check("t3_stall_data",   32'(m_data),     32'd2);
         end
         runCycle();
      end
      mReadyDrv = 1'b1;
      drain("t3", 50);
      check("t3_count", 32'(dataLog.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < dataLog.size()) check("t3_order", 32'(dataLog[k]), 32'(k + 1));
      end

      // ---- source bubble: src1 granted, drops valid for 3 cycles ----
      doReset();
      pushPacket(1, 4, 16'h0011);
      repeat (3) runCycle();
      stall[1] = 1'b1;
      pushPacket(0, 2, 16'h0021);
      for (int c = 0; c < 3; c++) begin
         runCycle();
         check("t4_src0_blocked", 32'(s_ready[0]), 32'd0);
      end
      stall[1] = 1'b0;
      drain("t4", 100);
      expSeq = '{1, 1, 1, 1, 0, 0};
      checkSrcSeq("t4_src_seq", expSeq);

      // ---- wrap-around: all three sources, 1-beat packets ----
      doReset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) pushPacket(i, 1, DW'(16 * i + r));
      end
      drain("t5", 100);
      expSeq = '{0, 1, 2, 0, 1, 2};
      checkSrcSeq("t5_src_seq", expSeq);
      for (int k = 0; k < 6; k++) begin
         if (k < lastLog.size()) check("t5_last", 32'(lastLog[k]), 32'd1);
      end

      // ---- reset mid-packet: ptr must return to 0 ----
      doReset();
      pushPacket(0, 1, 16'h00A0);
      pushPacket(1, 4, 16'h00B0);
      repeat (5) runCycle();
      check("t6_before_reset_valid", 32'(m_valid), 32'd1);
      check("t6_before_reset_src",   32'(m_src),   32'd1);
      doReset();
      pushPacket(0, 3, 16'h00C0);
      pushPacket(1, 1, 16'h00D0);
      drain("t6", 100);
      expSeq = '{0, 0, 0, 1};
      checkSrcSeq("t6_src_seq", expSeq);
      if (lastLog.size() == 4) begin
         check("t6_last2", 32'(lastLog[1]), 32'd0);
         check("t6_last3", 32'(lastLog[2]), 32'd1);
      end

      // ---- randomized traffic against the model ----
      doReset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ((srcQ[i].size() < 6) && ($urandom_range(0, 3) == 0))
               pushPacket(i, $urandom_range(1, 4), DW'($urandom));
            stall[i] = ($urandom_range(0, 4) == 0);
         end
         mReadyDrv = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 999) == 0) doReset();
         runCycle();
      end
      for (int i = 0; i < N; i++) stall[i] = 1'b0;
      mReadyDrv = 1'b1;
      drain("rand", 500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
